// File: rtl/bloom_lookup_client.sv
// bloom_lookup_client: single-outstanding sequencer between a keyed request stream and the
// bloom_filter insert/query port, returning one response per request plus hit/miss/insert stats.
module bloom_lookup_client #(
  parameter int CNT_W          = 16,
  parameter bit INSERT_ON_MISS = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_key,
  input  logic             req_insert,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_key,
  output logic             rsp_insert,
  output logic             rsp_hit,
  output logic             rsp_inserted,
  output logic             bf_insert_valid,
  output logic [31:0]      bf_insert_data,
  output logic             bf_query_valid,
  output logic [31:0]      bf_query_data,
  input  logic             bf_query_result,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] insert_count
);
  typedef enum logic [2:0] {IDLE, QRY, WAIT, INS, RESP} state_t;
  state_t state, state_nxt;
  logic [31:0] key;
  logic op, hit, inserted;
  logic accept, rsp_hs;
  assign accept = req_valid && req_ready;
  assign rsp_hs = rsp_valid && rsp_ready;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_valid ? (req_insert ? INS : QRY) : IDLE;
      QRY:     state_nxt = WAIT;
      WAIT:    state_nxt = (!bf_query_result && INSERT_ON_MISS) ? INS : RESP;
      INS:     state_nxt = RESP;
      RESP:    state_nxt = rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready       = state == IDLE;
    bf_query_valid  = state == QRY;
    bf_insert_valid = state == INS;
    rsp_valid       = state == RESP;
  end
  // The hit flag is cleared on accept so an explicit insert always reports a miss.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      key      <= '0;
      op       <= 1'b0;
      hit      <= 1'b0;
      inserted <= 1'b0;
    end else if (accept) begin
      key      <= req_key;
      op       <= req_insert;
      hit      <= 1'b0;
      inserted <= 1'b0;
    end else if (state == WAIT) begin
      hit      <= bf_query_result;
    end else if (state == INS) begin
      inserted <= 1'b1;
    end
  assign rsp_key        = key;
  assign rsp_insert     = op;
  assign rsp_hit        = hit;
  assign rsp_inserted   = inserted;
  assign bf_insert_data = key;
  assign bf_query_data  = key;
  logic inc_hit, inc_miss, inc_ins;
  assign inc_hit  = rsp_hs && !op && hit && !(&hit_count);
  assign inc_miss = rsp_hs && !op && !hit && !(&miss_count);
  assign inc_ins  = rsp_hs && inserted && !(&insert_count);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      hit_count    <= '0;
      miss_count   <= '0;
      insert_count <= '0;
    end else begin
      hit_count    <= stat_clear ? '0 : inc_hit  ? hit_count + CNT_W'(1)    : hit_count;
      miss_count   <= stat_clear ? '0 : inc_miss ? miss_count + CNT_W'(1)   : miss_count;
      insert_count <= stat_clear ? '0 : inc_ins  ? insert_count + CNT_W'(1) : insert_count;
    end
endmodule

// File: tb/tb_bloom_lookup_client.sv
// tb_bloom_lookup_client: three client instances (default, insert-on-miss, 2-bit counters),
// each driving its own 1024-bit bloom filter model indexed by the key's low 10 bits.
module tb_bloom_lookup_client;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic        req_valid[N], req_ready[N], req_insert[N], rsp_valid[N], rsp_ready[N];
  logic        rsp_insert[N], rsp_hit[N], rsp_inserted[N], biv[N], bqv[N], bqr[N], stat_clear[N];
  logic [31:0] req_key[N], rsp_key[N], bid[N], bqd[N];
  logic [15:0] hc[N], mc[N], ic[N];
  int ins_pulses[N], qry_pulses[N];
  int compared = 0, mismatched = 0;
  typedef struct {
    int          g;
    logic [31:0] key;
    logic        ins, hit, inserted;
    int          lat;
  } exp_t;
  exp_t sb[$];
  logic [1023:0] ref_bits[N];

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] h, m, i;
    logic [1023:0] mem = '0;
    bloom_lookup_client #(.CNT_W(CW), .INSERT_ON_MISS(g == 1)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_key(req_key[g]),
      .req_insert(req_insert[g]), .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_key(rsp_key[g]), .rsp_insert(rsp_insert[g]), .rsp_hit(rsp_hit[g]),
      .rsp_inserted(rsp_inserted[g]), .bf_insert_valid(biv[g]), .bf_insert_data(bid[g]),
      .bf_query_valid(bqv[g]), .bf_query_data(bqd[g]), .bf_query_result(bqr[g]),
      .stat_clear(stat_clear[g]), .hit_count(h), .miss_count(m), .insert_count(i)
    );
    assign hc[g] = 16'(h);
    assign mc[g] = 16'(m);
    assign ic[g] = 16'(i);
    always @(posedge clk) begin
      if (biv[g]) mem[bid[g][9:0]] <= 1'b1;
      bqr[g] <= bqv[g] && mem[bqd[g][9:0]];
    end
  end

  always @(negedge clk)
    for (int g = 0; g < N; g++) begin
      if (biv[g]) ins_pulses[g]++;
      if (bqv[g]) qry_pulses[g]++;
    end

  // Push the expectation, run the request, and compare against the head when the response appears.
  task automatic issue(input int g, input logic [31:0] key, input logic ins);
    exp_t e;
    int k;
    e.g = g; e.key = key; e.ins = ins;
    e.hit = !ins && ref_bits[g][key[9:0]];
    e.inserted = ins || (g == 1 && !e.hit);
    e.lat = ins ? 2 : (e.inserted ? 4 : 3);
    if (e.inserted) ref_bits[g][key[9:0]] = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    req_valid[g] = 1'b1; req_key[g] = key; req_insert[g] = ins;
    k = 0;
    while (!req_ready[g] && k < 20) begin @(negedge clk); k++; end
    compared++;
    if (req_ready[g] !== 1'b1) begin mismatched++; $display("FAIL accept u%0d: req_ready %b want 1", g, req_ready[g]); end
    @(posedge clk);
    #1 req_valid[g] = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid[g] && k < 30);
    e = sb.pop_front();
    compared += 5;
    if (k !== e.lat) begin mismatched++; $display("FAIL latency u%0d key=%h: got %0d want %0d", g, key, k, e.lat); end
    if (rsp_key[g] !== e.key) begin mismatched++; $display("FAIL rsp_key u%0d: got %h want %h", g, rsp_key[g], e.key); end
    if (rsp_insert[g] !== e.ins) begin mismatched++; $display("FAIL rsp_insert u%0d: got %b want %b", g, rsp_insert[g], e.ins); end
    if (rsp_hit[g] !== e.hit) begin mismatched++; $display("FAIL rsp_hit u%0d key=%h: got %b want %b", g, key, rsp_hit[g], e.hit); end
    if (rsp_inserted[g] !== e.inserted) begin mismatched++; $display("FAIL rsp_inserted u%0d key=%h: got %b want %b", g, key, rsp_inserted[g], e.inserted); end
  endtask

  task automatic ack(input int g);
    rsp_ready[g] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      compared += 6;
      if (req_ready[g] !== 1'b1) begin mismatched++; $display("FAIL reset req_ready u%0d: got %b want 1", g, req_ready[g]); end
      if (rsp_valid[g] !== 1'b0) begin mismatched++; $display("FAIL reset rsp_valid u%0d: got %b want 0", g, rsp_valid[g]); end
      if ({biv[g], bqv[g]} !== 2'b00) begin mismatched++; $display("FAIL reset strobes u%0d: got %b%b want 00", g, biv[g], bqv[g]); end
      if ({bid[g], bqd[g]} !== 64'd0) begin mismatched++; $display("FAIL reset bf_data u%0d: got %h/%h want 0", g, bid[g], bqd[g]); end
      if (rsp_key[g] !== 32'd0) begin mismatched++; $display("FAIL reset rsp_key u%0d: got %h want 0", g, rsp_key[g]); end
      if ({hc[g], mc[g], ic[g]} !== 48'd0) begin mismatched++; $display("FAIL reset counters u%0d: got %0d/%0d/%0d want 0", g, hc[g], mc[g], ic[g]); end
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_query_miss;
    int p;
    p = ins_pulses[0];
    issue(0, 32'h0000_0005, 1'b0);
    ack(0);
    compared += 3;
    if ({hc[0], mc[0], ic[0]} !== {16'd0, 16'd1, 16'd0}) begin mismatched++; $display("FAIL miss counters: got %0d/%0d/%0d want 0/1/0", hc[0], mc[0], ic[0]); end
    if (ins_pulses[0] !== p) begin mismatched++; $display("FAIL miss insert strobe: got %0d pulses want %0d", ins_pulses[0], p); end
    if (bqd[0] !== 32'h5) begin mismatched++; $display("FAIL query data hold: got %h want 00000005", bqd[0]); end
  endtask

  task automatic test_alias_hit;
    issue(0, 32'h0000_0005, 1'b1);
    ack(0);
    issue(0, 32'h0000_0405, 1'b0);
    ack(0);
    compared++;
    if ({hc[0], mc[0], ic[0]} !== {16'd1, 16'd1, 16'd1}) begin mismatched++; $display("FAIL alias counters: got %0d/%0d/%0d want 1/1/1", hc[0], mc[0], ic[0]); end
  endtask

  task automatic test_insert_on_miss;
    issue(1, 32'h77, 1'b0);
    ack(1);
    issue(1, 32'h77, 1'b0);
    ack(1);
    compared++;
    if ({hc[1], mc[1], ic[1]} !== {16'd1, 16'd1, 16'd1}) begin mismatched++; $display("FAIL iom counters: got %0d/%0d/%0d want 1/1/1", hc[1], mc[1], ic[1]); end
  endtask

  task automatic test_stall;
    int qp, ip;
    issue(0, 32'h0000_0405, 1'b0);
    qp = qry_pulses[0]; ip = ins_pulses[0];
    req_valid[0] = 1'b1; req_key[0] = 32'hABC; req_insert[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      compared += 3;
      if ({rsp_valid[0], rsp_hit[0], rsp_key[0]} !== {2'b11, 32'h405}) begin mismatched++; $display("FAIL stall rsp: got v=%b h=%b k=%h want 1 1 405", rsp_valid[0], rsp_hit[0], rsp_key[0]); end
      if (req_ready[0] !== 1'b0) begin mismatched++; $display("FAIL stall req_ready: got %b want 0", req_ready[0]); end
      if ({biv[0], bqv[0]} !== 2'b00) begin mismatched++; $display("FAIL stall strobes: got %b%b want 00", biv[0], bqv[0]); end
    end
    req_valid[0] = 1'b0;
    ack(0);
    compared += 3;
    if (req_ready[0] !== 1'b1) begin mismatched++; $display("FAIL stall release req_ready: got %b want 1", req_ready[0]); end
    if (qry_pulses[0] !== qp || ins_pulses[0] !== ip) begin mismatched++; $display("FAIL stall pulses: got %0d/%0d want %0d/%0d", qry_pulses[0], ins_pulses[0], qp, ip); end
    if (hc[0] !== 16'd2) begin mismatched++; $display("FAIL stall hit_count: got %0d want 2", hc[0]); end
  endtask

  task automatic test_saturate_clear;
    for (int i = 0; i < 4; i++) begin
      issue(2, 32'h10 + 32'(i), 1'b0);
      ack(2);
      compared++;
      if (mc[2] !== 16'((i + 1 > 3) ? 3 : i + 1)) begin mismatched++; $display("FAIL saturate miss_count step %0d: got %0d want %0d", i, mc[2], (i + 1 > 3) ? 3 : i + 1); end
    end
    issue(2, 32'h20, 1'b1);
    ack(2);
    compared++;
    if (ic[2] !== 16'd1) begin mismatched++; $display("FAIL saturate insert_count: got %0d want 1", ic[2]); end
    issue(2, 32'h20, 1'b0);
    stat_clear[2] = 1'b1;
    ack(2);
    stat_clear[2] = 1'b0;
    compared++;
    if ({hc[2], mc[2], ic[2]} !== 48'd0) begin mismatched++; $display("FAIL clear wins: got %0d/%0d/%0d want 0/0/0", hc[2], mc[2], ic[2]); end
  endtask

  task automatic test_reset_mid;
    int ip, qp;
    ip = ins_pulses[1]; qp = qry_pulses[1];
    @(negedge clk);
    req_valid[1] = 1'b1; req_key[1] = 32'h99; req_insert[1] = 1'b0;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    compared += 3;
    if (qry_pulses[1] !== qp + 1) begin mismatched++; $display("FAIL midreset query issued: got %0d want %0d", qry_pulses[1], qp + 1); end
    if ({rsp_valid[1], req_ready[1]} !== 2'b01) begin mismatched++; $display("FAIL midreset state: got v=%b r=%b want 0 1", rsp_valid[1], req_ready[1]); end
    if ({hc[1], mc[1], ic[1]} !== 48'd0) begin mismatched++; $display("FAIL midreset counters: got %0d/%0d/%0d want 0", hc[1], mc[1], ic[1]); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      compared++;
      if ({rsp_valid[1], req_ready[1]} !== 2'b01) begin mismatched++; $display("FAIL after reset: got v=%b r=%b want 0 1", rsp_valid[1], req_ready[1]); end
    end
    compared++;
    if (ins_pulses[1] !== ip) begin mismatched++; $display("FAIL midreset insert strobe: got %0d want %0d", ins_pulses[1], ip); end
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      req_valid[g] = 1'b0; req_key[g] = '0; req_insert[g] = 1'b0;
      rsp_ready[g] = 1'b0; stat_clear[g] = 1'b0; ref_bits[g] = '0;
    end
    test_reset;
    test_query_miss;
    test_alias_hit;
    test_insert_on_miss;
    test_stall;
    test_saturate_clear;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
